// File: rtl/data_bus_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_pkg
// Shared definitions for the data-bus masters: arbiter state encoding, default
// data width, hardware register page select value, register index width and
// the register-page decode helper.
// -----------------------------------------------------------------------------
package data_bus_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_WIDTH = 19;
  localparam int unsigned REG_IDX_W  = 12;
  localparam int unsigned REG_VAL_W  = 16;
  localparam logic [3:0]  REG_PAGE   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOST   = 2'd1,
    REPLAY = 2'd2
  } arb_state_t;

  // True when the address falls in the hardware register page.
  function automatic logic page_select(input logic [ADDR_W-1:0] addr,
                                       input logic [3:0]        page);
    return addr[ADDR_W-1 -: 4] == page;
  endfunction

endpackage

// File: rtl/bus_decode.sv
// -----------------------------------------------------------------------------
// bus_decode
// Splits one bus master's access between data RAM and the register page and
// steers the returned read data (one-cycle latency on both sides).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_addr/i_wdata/i_we access from the selected master
//   i_en                access allowed; when low no write or register strobe
//   o_mem_*             RAM address / write data / write enable
//   i_mem_rdata         RAM read data
//   o_reg_*             register index / read / write strobes / write value
//   i_reg_rvalue        register read data
//   o_rdata             steered read data for the previous cycle's access
// -----------------------------------------------------------------------------
module bus_decode #(
  parameter int unsigned DATA_WIDTH = data_bus_pkg::DATA_WIDTH,
  parameter logic [3:0]  REG_PAGE   = data_bus_pkg::REG_PAGE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [data_bus_pkg::ADDR_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0]                i_wdata,
  input  logic                                 i_we,
  input  logic                                 i_en,
  output logic [data_bus_pkg::ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_WIDTH-1:0]                o_mem_wdata,
  output logic                                 o_mem_we,
  input  logic [DATA_WIDTH-1:0]                i_mem_rdata,
  output logic [data_bus_pkg::REG_IDX_W-1:0]   o_reg_index,
  output logic                                 o_reg_read,
  output logic                                 o_reg_write,
  output logic [data_bus_pkg::REG_VAL_W-1:0]   o_reg_wvalue,
  input  logic [data_bus_pkg::REG_VAL_W-1:0]   i_reg_rvalue,
  output logic [DATA_WIDTH-1:0]                o_rdata
);
  import data_bus_pkg::*;

  logic w_page;
  logic r_reg_src;

  assign w_page       = page_select(i_addr, REG_PAGE);

  assign o_mem_addr   = i_addr;
  assign o_mem_wdata  = i_wdata;
  assign o_mem_we     = i_en &  i_we & ~w_page;
  assign o_reg_read   = i_en & ~i_we &  w_page;
  assign o_reg_write  = i_en &  i_we &  w_page;
  assign o_reg_index  = i_addr[REG_IDX_W-1:0];
  assign o_reg_wvalue = i_wdata[REG_VAL_W-1:0];

  // Remembers which side the previous cycle's access went to.
  always_ff @(posedge clk) begin
    if (reset) r_reg_src <= 1'b0;
    else       r_reg_src <= w_page;
  end

  assign o_rdata = r_reg_src ? DATA_WIDTH'(i_reg_rvalue) : i_mem_rdata;

endmodule

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
// Owns the data bus below the core (data RAM + register page 0xF000-0xFFFF).
// A host/debug requester steals bus cycles by stalling the core for two cycles
// (HOST, REPLAY); REPLAY re-reads the core's last address so the core receives
// correct read data on its first unstalled cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   core_*                     core access, read data, stall (clock enable)
//   mem_*                      data RAM (one-cycle read latency)
//   register_*                 hardware register page (one-cycle read latency)
//   host_req/we/addr/wdata     host request, held until host_ack
//   host_ack/err/rdata         one-cycle completion with status and read data
//   stat_host_cycles/errs      saturating host ack / error counters, present
//                              only when ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int unsigned MEM_SIZE   = 2048,
  parameter int unsigned DATA_WIDTH = data_bus_pkg::DATA_WIDTH,
  parameter logic [3:0]  REG_PAGE   = data_bus_pkg::REG_PAGE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  core_we,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  output logic [15:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [11:0]           register_index,
  output logic                  register_read,
  output logic                  register_write,
  output logic [15:0]           register_write_value,
  input  logic [15:0]           register_read_value,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [15:0]           host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  host_err,
  output logic [DATA_WIDTH-1:0] host_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           stat_host_cycles,
  output logic [7:0]            stat_host_errs
`endif
);
  import data_bus_pkg::*;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [15:0]           r_last_core_addr;
  logic                  r_host_err;

  logic                  w_host_ok;
  logic [15:0]           w_bus_addr;
  logic [DATA_WIDTH-1:0] w_bus_wdata;
  logic                  w_bus_we;
  logic                  w_bus_en;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_host_ok = (32'(host_addr) < MEM_SIZE) || page_select(host_addr, REG_PAGE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a host access always takes exactly HOST then REPLAY, and the
  // return to IDLE guarantees the core one unstalled cycle between accesses.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (host_req) w_state_nxt = HOST;
      HOST:    w_state_nxt = REPLAY;
      REPLAY:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus source selection and status outputs.
  always_comb begin
    w_bus_addr  = core_addr;
    w_bus_wdata = core_wdata;
    w_bus_we    = core_we;
    w_bus_en    = 1'b1;
    core_stall  = 1'b0;
    host_ack    = 1'b0;
    host_err    = 1'b0;
    host_rdata  = '0;
    case (r_state)
      HOST: begin
        core_stall  = 1'b1;
        w_bus_addr  = host_addr;
        w_bus_wdata = host_wdata;
        w_bus_we    = host_we;
        w_bus_en    = w_host_ok;
      end
      REPLAY: begin
        core_stall  = 1'b1;
        w_bus_addr  = r_last_core_addr;
        w_bus_we    = 1'b0;
        // A reset landing on REPLAY abandons the access without an ack.
        host_ack    = ~reset;
        host_err    = ~reset & r_host_err;
        host_rdata  = r_host_err ? '0 : w_rdata;
      end
      default: ;
    endcase
  end

  // Core address capture for replay and host error latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_core_addr <= '0;
      r_host_err       <= 1'b0;
    end else begin
      if (r_state == IDLE) r_last_core_addr <= core_addr;
      if (r_state == HOST) r_host_err       <= ~w_host_ok;
    end
  end

  bus_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_PAGE   (REG_PAGE)
  ) u_bus_decode (
    .clk          (clk),
    .reset        (reset),
    .i_addr       (w_bus_addr),
    .i_wdata      (w_bus_wdata),
    .i_we         (w_bus_we),
    .i_en         (w_bus_en),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_we     (mem_we),
    .i_mem_rdata  (mem_rdata),
    .o_reg_index  (register_index),
    .o_reg_read   (register_read),
    .o_reg_write  (register_write),
    .o_reg_wvalue (register_write_value),
    .i_reg_rvalue (register_read_value),
    .o_rdata      (w_rdata)
  );

  assign core_rdata = w_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_host_cycles;
  logic [7:0]  r_stat_host_errs;

  // Saturating host completion / error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_host_cycles <= '0;
      r_stat_host_errs   <= '0;
    end else if (host_ack) begin
      if (r_stat_host_cycles != 16'hFFFF) r_stat_host_cycles <= r_stat_host_cycles + 16'd1;
      if (host_err && (r_stat_host_errs != 8'hFF)) r_stat_host_errs <= r_stat_host_errs + 8'd1;
    end
  end

  assign stat_host_cycles = r_stat_host_cycles;
  assign stat_host_errs   = r_stat_host_errs;
`endif

endmodule
